// File: rtl/dot_channel_acc.sv
// ---------------------------------------------------------------------------
// dot_channel_acc
//
// Pipelined fixed-point dot-product accumulator. Each accepted beat carries
// LANES signed data/weight pairs; their products are summed and accumulated
// over N_PASS beats, then the accumulator is rescaled by FRAC and presented
// on q with a valid/ready handshake.
//
// Pipeline: stage 1 registers the per-lane products, stage 2 registers their
// sign-extended sum, stage 3 folds that sum into the accumulator. out_valid
// rises three cycles after the edge that accepts the last beat of a result.
//
// Optional feature macro: DOT_CHANNEL_ACC_SAT_EN
//   defined   -> q saturates to the signed DATA_W range
//   undefined -> q takes the low DATA_W bits of the shifted value (wraps)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   clr        synchronous abort of the current result
//   in_valid   beat offered
//   in_ready   beat can be accepted
//   d, w       data / weight vectors, lane i at [i*DATA_W +: DATA_W]
//   out_valid  result available
//   out_ready  result consumed
//   q          result
// ---------------------------------------------------------------------------
module dot_channel_acc #(
    parameter int LANES  = 36,
    parameter int N_PASS = 6,
    parameter int DATA_W = 16,
    parameter int FRAC   = 8,
    parameter int ACC_W  = 2*DATA_W+8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] d,
    input  logic [LANES*DATA_W-1:0] w,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       q
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [7:0] PASS_LAST = 8'(N_PASS - 1);

    state_t state_q, state_d;
    logic [1:0] drain_q, drain_d;
    logic [7:0] pass_q;
    logic       accept;
    logic       last_beat;

    logic signed [2*DATA_W-1:0] s1_prod [LANES];
    logic                       s1_valid, s1_first;
    logic signed [ACC_W-1:0]    s1_sum;
    logic signed [ACC_W-1:0]    s2_sum;
    logic                       s2_valid, s2_first;
    logic signed [ACC_W-1:0]    acc;

    // Handshake decode and next state. clr overrides any accept or output
    // handshake in the same cycle.
    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        in_ready  = (state_q == IDLE) || (state_q == ACCUM);
        out_valid = (state_q == HOLD);
        accept    = in_valid && in_ready && !clr;
        last_beat = (pass_q == PASS_LAST);

        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_d = last_beat ? DRAIN : ACCUM;
                    drain_d = 2'd0;
                end
            end
            DRAIN: begin
                // Last beat needs three edges to reach the accumulator output.
                if (drain_q == 2'd2) begin
                    state_d = HOLD;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clr) begin
            state_d = IDLE;
            drain_d = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            drain_q <= 2'd0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q <= 8'd0;
        end else if (clr) begin
            pass_q <= 8'd0;
        end else if (accept) begin
            pass_q <= last_beat ? 8'd0 : pass_q + 8'd1;
        end
    end

    // Stage 1: per-lane signed products. s1_first marks the beat that must
    // load rather than add into the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                s1_prod[i] <= '0;
            end
        end else if (clr) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                s1_prod[i] <= '0;
            end
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_first <= (pass_q == 8'd0);
                for (int i = 0; i < LANES; i++) begin
                    s1_prod[i] <= $signed(d[i*DATA_W +: DATA_W]) *
                                  $signed(w[i*DATA_W +: DATA_W]);
                end
            end
        end
    end

    always_comb begin
        s1_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            s1_sum = s1_sum +
                     {{(ACC_W-2*DATA_W){s1_prod[i][2*DATA_W-1]}}, s1_prod[i]};
        end
    end

    // Stage 2: registered lane sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_sum   <= '0;
        end else if (clr) begin
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_sum   <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_first <= s1_first;
            if (s1_valid) begin
                s2_sum <= s1_sum;
            end
        end
    end

    // Stage 3: accumulator; overflow wraps at ACC_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (s2_valid) begin
            acc <= s2_first ? s2_sum : acc + s2_sum;
        end
    end

`ifdef DOT_CHANNEL_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] Q_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Q_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = acc >>> FRAC;
        if (shifted > Q_MAX) begin
            q = Q_MAX[DATA_W-1:0];
        end else if (shifted < Q_MIN) begin
            q = Q_MIN[DATA_W-1:0];
        end else begin
            q = shifted[DATA_W-1:0];
        end
    end
`else
    // Taking bits [FRAC +: DATA_W] is the arithmetic shift followed by a
    // wrap to DATA_W bits.
    assign q = acc[FRAC +: DATA_W];
`endif

endmodule

// File: tb/tb_dot_channel_acc.sv
// ---------------------------------------------------------------------------
// tb_dot_channel_acc
//
// Self-checking bench for dot_channel_acc with LANES=4, N_PASS=2, DATA_W=16,
// FRAC=8. A table of two-beat vectors with hand-computed results is applied
// in a loop; hand-written sequences cover gaps, output stall, clr and reset
// in the middle of a result. Expected q depends on DOT_CHANNEL_ACC_SAT_EN.
// ---------------------------------------------------------------------------
module tb_dot_channel_acc;

    localparam int LANES  = 4;
    localparam int N_PASS = 2;
    localparam int DATA_W = 16;
    localparam int FRAC   = 8;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    clr = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] d = '0;
    logic [LANES*DATA_W-1:0] w = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [DATA_W-1:0]       q;

    int checks = 0;
    int errors = 0;

    dot_channel_acc #(
        .LANES (LANES),
        .N_PASS(N_PASS),
        .DATA_W(DATA_W),
        .FRAC  (FRAC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .d        (d),
        .w        (w),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .q        (q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d1;
        logic [63:0] w1;
        logic [63:0] d2;
        logic [63:0] w2;
        logic [15:0] q_wrap;
        logic [15:0] q_sat;
    } vec_t;

    vec_t vecs [6];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Offers one beat; it is accepted on the following rising edge.
    task automatic applyStimulus(input logic [63:0] dv, input logic [63:0] wv,
                                 input string name);
        @(negedge clk);
        in_valid = 1'b1;
        d        = dv;
        w        = wv;
        checkOutput({name, " in_ready before accept"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Called right after the last beat's accepting edge.
    task automatic expectResult(input logic [15:0] exp_q, input string name);
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("%s out_valid at +%0d", name, cyc),
                        32'(out_valid), (cyc == 3) ? 32'd1 : 32'd0);
            checkOutput($sformatf("%s in_ready at +%0d", name, cyc),
                        32'(in_ready), 32'd0);
        end
        checkOutput({name, " q"}, 32'(q), 32'(exp_q));
    endtask

    task automatic releaseResult(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({name, " out_valid after release"}, 32'(out_valid), 32'd0);
        checkOutput({name, " in_ready after release"}, 32'(in_ready), 32'd1);
    endtask

    function automatic logic [15:0] pick(input vec_t v);
`ifdef DOT_CHANNEL_ACC_SAT_EN
        return v.q_sat;
`else
        return v.q_wrap;
`endif
    endfunction

    localparam logic [63:0] ONE    = {4{16'h0100}};
    localparam logic [63:0] NEG1   = {4{16'hFF00}};
    localparam logic [63:0] MAXP   = {4{16'h7FFF}};
    localparam logic [63:0] MINN   = {4{16'h8000}};
    localparam logic [63:0] LSBNEG = {4{16'hFFFF}};
    localparam logic [63:0] LSB1   = {4{16'h0001}};

    initial begin
        logic [15:0] held_q;

        // 1.0*1.0 per lane, 8 products -> 8.0
        vecs[0] = '{ONE, ONE, ONE, ONE, 16'h0800, 16'h0800};
        // 8*0x3FFF0001 = 0x1_FFF8_0008, >>>8 = 0x1FFF800: wraps to 0xF800
        vecs[1] = '{MAXP, MAXP, MAXP, MAXP, 16'hF800, 16'h7FFF};
        // 8 * (1.0 * -1.0) = -8.0
        vecs[2] = '{ONE, NEG1, ONE, NEG1, 16'hF800, 16'hF800};
        // lanes 2*1 + 0.5*2 - 0.5*1 + 1*3 = 5.5, second beat zero weights
        vecs[3] = '{{16'h0100, 16'hFF80, 16'h0080, 16'h0200},
                    {16'h0300, 16'h0100, 16'h0200, 16'h0100},
                    ONE, 64'h0, 16'h0580, 16'h0580};
        // sum -8 raw LSBs, >>>8 floors to -1
        vecs[4] = '{LSBNEG, LSB1, LSBNEG, LSB1, 16'hFFFF, 16'hFFFF};
        // 8 * -0x3FFF8000 = -0x1_FFFC_0000, >>>8 = -0x1FFFC00: wraps to 0x0400
        vecs[5] = '{MINN, MAXP, MINN, MAXP, 16'h0400, 16'h8000};

        // Reset state
        #2;
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset q", 32'(q), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors, back to back
        for (int i = 0; i < 6; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            applyStimulus(vecs[i].d1, vecs[i].w1, {nm, " beat1"});
            applyStimulus(vecs[i].d2, vecs[i].w2, {nm, " beat2"});
            expectResult(pick(vecs[i]), nm);
            releaseResult(nm);
        end

        // Gap of 5 idle cycles between beats
        applyStimulus(ONE, NEG1, "gap beat1");
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("gap in_ready c%0d", c), 32'(in_ready), 32'd1);
            checkOutput($sformatf("gap out_valid c%0d", c), 32'(out_valid), 32'd0);
        end
        applyStimulus(ONE, NEG1, "gap beat2");
        expectResult(16'hF800, "gap");
        releaseResult("gap");

        // Output stall for 10 cycles with junk beats offered
        applyStimulus(ONE, ONE, "stall beat1");
        applyStimulus(ONE, ONE, "stall beat2");
        expectResult(16'h0800, "stall");
        held_q = q;
        @(negedge clk);
        in_valid = 1'b1;
        d        = MAXP;
        w        = MAXP;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("stall out_valid c%0d", c), 32'(out_valid), 32'd1);
            checkOutput($sformatf("stall q c%0d", c), 32'(q), 32'(held_q));
            checkOutput($sformatf("stall in_ready c%0d", c), 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        releaseResult("stall");
        applyStimulus(ONE, ONE, "post-stall beat1");
        applyStimulus(ONE, ONE, "post-stall beat2");
        expectResult(16'h0800, "post-stall");
        releaseResult("post-stall");

        // clr after beat 1, clr overriding an offered beat, then fresh result
        applyStimulus(MAXP, MAXP, "clr beat1");
        @(negedge clk);
        clr      = 1'b1;
        in_valid = 1'b1;
        d        = MAXP;
        w        = MAXP;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        checkOutput("clr in_ready", 32'(in_ready), 32'd1);
        checkOutput("clr out_valid", 32'(out_valid), 32'd0);
        checkOutput("clr q", 32'(q), 32'd0);
        applyStimulus(ONE, ONE, "after clr beat1");
        applyStimulus(ONE, ONE, "after clr beat2");
        expectResult(16'h0800, "after clr");
        releaseResult("after clr");

        // Reset while holding a result
        applyStimulus(ONE, ONE, "hold-reset beat1");
        applyStimulus(ONE, ONE, "hold-reset beat2");
        expectResult(16'h0800, "hold-reset");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset in HOLD out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset in HOLD q", 32'(q), 32'd0);
        checkOutput("reset in HOLD in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-accumulation: the next result must start from beat 0
        applyStimulus(MAXP, MAXP, "mid-reset beat1");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("mid-reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(ONE, NEG1, "after reset beat1");
        @(posedge clk);
        #1;
        checkOutput("after reset still accumulating", 32'(in_ready), 32'd1);
        applyStimulus(ONE, NEG1, "after reset beat2");
        expectResult(16'hF800, "after reset");
        releaseResult("after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the bench always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
